univ_shift_reg: RTL and testbench

- Parametrised universal shift register; successor to the team's 2-bit-control shift register.
- Adds lane-width (multi-bit) shifting, both directions, rotate, arithmetic shift and synchronous clear.
- Tracks shifts since the last load with a counter and a one-cycle "word done" pulse.
- Used as a serializer/deserializer front end (UART/SPI-style datapaths) in the same design tree.

---
 rtl/shift_pkg.sv | 46 ++++
 rtl/univ_shift_cnt.sv | 44 ++++
 rtl/univ_shift_reg.sv | 76 +++++++
 tb/tb_univ_shift_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and next-state helper for the universal shift register.
// next_val works on MAXN-wide vectors; callers pass their real N and W.
package shift_pkg;

    localparam int MAXN = 64;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        SHR  = 3'b001,
        SHL  = 3'b010,
        LOAD = 3'b011,
        ROR  = 3'b100,
        ROL  = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } mode_t;

    function automatic logic [MAXN-1:0] next_val(
        input mode_t           m,
        input logic [MAXN-1:0] r,
        input logic [MAXN-1:0] s_in_l,
        input logic [MAXN-1:0] s_in_r,
        input logic [MAXN-1:0] d,
        input int              n,
        input int              w
    );
        logic [MAXN-1:0] v;
        v = '0;
        for (int i = 0; i < MAXN; i++) begin
            if (i < n) begin
                case (m)
                    SHR:     v[i] = (i + w < n) ? r[i + w] : s_in_l[i + w - n];
                    SHL:     v[i] = (i >= w) ? r[i - w] : s_in_r[i];
                    LOAD:    v[i] = d[i];
                    ROR:     v[i] = r[(i + w) % n];
                    ROL:     v[i] = r[(i + n - w) % n];
                    ASR:     v[i] = (i + w < n) ? r[i + w] : r[n - 1];
                    CLR:     v[i] = 1'b0;
                    default: v[i] = r[i];
                endcase
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/univ_shift_cnt.sv
// Saturating shift counter with a one-cycle pulse when the word completes.
module shift_cnt #(
    parameter int MAX = 8,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && cnt_q != CW'(MAX)) begin
                cnt_d  = cnt_q + 1'b1;
                done_d = (cnt_q == CW'(MAX - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: lane shifts, rotates, ASR, load, clear,
// plus a count of shifts since the last load and a word-done pulse.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  mode_t                      ctrl,
    input  logic [W-1:0]               s_in_l,
    input  logic [W-1:0]               s_in_r,
    input  logic [N-1:0]               d,
    output logic [N-1:0]               q,
    output logic [W-1:0]               s_out_r,
    output logic [W-1:0]               s_out_l,
    output logic [$clog2(N/W+1)-1:0]   cnt,
    output logic                       done
);

    localparam int WORDS = N / W;
    localparam int CW    = $clog2(WORDS + 1);

    generate
        if (W < 1 || W >= N || (N % W) != 0 || N > MAXN) begin : g_bad_params
            $error("univ_shift_reg: illegal N/W combination");
        end
    endgenerate

    logic [N-1:0] r_q, r_d;
    logic         is_shift;
    logic         is_clr;

    always_comb begin
        r_d = N'(next_val(ctrl, MAXN'(r_q), MAXN'(s_in_l),
                          MAXN'(s_in_r), MAXN'(d), N, W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_d;
        end
    end

    always_comb begin
        is_shift = 1'b0;
        is_clr   = 1'b0;
        case (ctrl)
            SHR, SHL, ROR, ROL, ASR: is_shift = 1'b1;
            LOAD, CLR:               is_clr   = 1'b1;
            default:                 ;
        endcase
    end

    shift_cnt #(
        .MAX (WORDS),
        .CW  (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (is_clr),
        .inc  (is_shift),
        .cnt  (cnt),
        .done (done)
    );

    assign q       = r_q;
    assign s_out_r = r_q[W-1:0];
    assign s_out_l = r_q[N-1:N-W];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed checks on N=8 (W=1, W=2) and a randomised run on N=16, W=4
// against an arithmetic reference model.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst, en;

    mode_t       ca, cb, cc;
    logic [7:0]  da, db;
    logic [15:0] dc;
    logic        sla, sra;
    logic [1:0]  slb, srb;
    logic [3:0]  slc, src;

    logic [7:0]  qa, qb;
    logic [15:0] qc;
    logic        sora, sola;
    logic [1:0]  sorb, solb;
    logic [3:0]  sorc, solc;
    logic [3:0]  cnta;
    logic [2:0]  cntb, cntc;
    logic        donea, doneb, donec;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.N(8), .W(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .ctrl(ca), .s_in_l(sla), .s_in_r(sra),
        .d(da), .q(qa), .s_out_r(sora), .s_out_l(sola), .cnt(cnta), .done(donea)
    );

    univ_shift_reg #(.N(8), .W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .ctrl(cb), .s_in_l(slb), .s_in_r(srb),
        .d(db), .q(qb), .s_out_r(sorb), .s_out_l(solb), .cnt(cntb), .done(doneb)
    );

    univ_shift_reg #(.N(16), .W(4)) dut_c (
        .clk(clk), .rst(rst), .en(en), .ctrl(cc), .s_in_l(slc), .s_in_r(src),
        .d(dc), .q(qc), .s_out_r(sorc), .s_out_l(solc), .cnt(cntc), .done(donec)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  word;
    logic [15:0] mr, nr;
    int          mc;
    logic        md;

    initial begin
        rst = 1'b1; en = 1'b1;
        ca = HOLD; cb = HOLD; cc = HOLD;
        da = '0; db = '0; dc = '0;
        sla = 1'b0; sra = 1'b0; slb = '0; srb = '0; slc = '0; src = '0;
        #2;
        check("rst_q", 32'(qa), 32'h0);
        check("rst_cnt", 32'(cnta), 32'h0);
        check("rst_done", 32'(donea), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // asynchronous reset in the middle of a shift sequence
        ca = LOAD; da = 8'hA5; tick();
        ca = SHR; tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("async_q", 32'(qa), 32'h0);
        check("async_cnt", 32'(cnta), 32'h0);
        check("async_done", 32'(donea), 32'h0);
        check("async_sor", 32'(sora), 32'h0);
        rst = 1'b0; ca = HOLD;
        tick();

        // load then 8 right shifts, W=1
        ca = LOAD; da = 8'hA5; tick();
        check("ld_q", 32'(qa), 32'hA5);
        check("ld_cnt", 32'(cnta), 32'h0);
        word = 8'hA5;
        ca = SHR; sla = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("shr_sor", 32'(sora), 32'(word[i]));
            tick();
            if (i == 6) check("shr_done7", 32'(donea), 32'h0);
        end
        check("shr_q8", 32'(qa), 32'h0);
        check("shr_done8", 32'(donea), 32'h1);
        check("shr_cnt8", 32'(cnta), 32'h8);
        tick();
        check("sat_cnt", 32'(cnta), 32'h8);
        check("sat_done", 32'(donea), 32'h0);

        // enable gating and LOAD priority over completion
        ca = LOAD; da = 8'h3C; tick();
        en = 1'b0; ca = SHR;
        tick(); tick(); tick();
        check("en_q", 32'(qa), 32'h3C);
        check("en_cnt", 32'(cnta), 32'h0);
        en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("pre_cnt", 32'(cnta), 32'h7);
        ca = LOAD; da = 8'hFF; tick();
        check("pri_q", 32'(qa), 32'hFF);
        check("pri_cnt", 32'(cnta), 32'h0);
        check("pri_done", 32'(donea), 32'h0);
        ca = CLR; tick();
        check("clr_q", 32'(qa), 32'h0);
        ca = HOLD;

        // rotates, W=2
        cb = LOAD; db = 8'h81; tick();
        cb = ROL; tick();
        check("rol_q", 32'(qb), 32'h06);
        check("rol_cnt", 32'(cntb), 32'h1);
        cb = LOAD; db = 8'h81; tick();
        cb = ROR;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ror_done", 32'(doneb), (i == 3) ? 32'h1 : 32'h0);
        end
        check("ror_q", 32'(qb), 32'h81);
        cb = HOLD; tick();
        check("ror_done_off", 32'(doneb), 32'h0);

        // arithmetic shift and left shift, W=2
        cb = LOAD; db = 8'h90; tick();
        cb = ASR; tick();
        check("asr1", 32'(qb), 32'hE4);
        tick();
        check("asr2", 32'(qb), 32'hF9);
        check("asr_sol", 32'(solb), 32'h3);
        cb = LOAD; db = 8'h90; tick();
        cb = SHL; srb = 2'b11; tick();
        check("shl_q", 32'(qb), 32'h43);
        cb = HOLD;

        // randomised sequence, N=16 W=4, reference from shift arithmetic
        mr = '0; mc = 0; md = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cc  = mode_t'($urandom_range(0, 7));
            dc  = 16'($urandom);
            slc = 4'($urandom);
            src = 4'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            case (cc)
                SHR:     nr = (mr >> 4) | (16'(slc) << 12);
                SHL:     nr = (mr << 4) | 16'(src);
                LOAD:    nr = dc;
                ROR:     nr = (mr >> 4) | (mr << 12);
                ROL:     nr = (mr << 4) | (mr >> 12);
                ASR:     nr = 16'($signed(mr) >>> 4);
                CLR:     nr = '0;
                default: nr = mr;
            endcase
            md = 1'b0;
            if (en) begin
                mr = nr;
                if (cc == LOAD || cc == CLR) begin
                    mc = 0;
                end else if (cc != HOLD && mc < 4) begin
                    md = (mc == 3);
                    mc = mc + 1;
                end
            end
            tick();
            check("rnd_q", 32'(qc), 32'(mr));
            check("rnd_cnt", 32'(cntc), 32'(mc));
            check("rnd_done", 32'(donec), 32'(md));
            check("rnd_sor", 32'(sorc), 32'(mr[3:0]));
            check("rnd_sol", 32'(solc), 32'(mr[15:12]));
        end
        en = 1'b1; cc = HOLD;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
